// File: rtl/mat_add_seq_pkg.sv
// mat_add_seq shared definitions:
// FSM state encoding, element width and a leading-one helper.
package mat_add_seq_pkg;

   localparam int EW = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RELEASE,
      S_DONE
   } state_t;

   function automatic logic [4:0] f_msb(input logic [26:0] v);
      logic [4:0] p;
      p = '0;
      for (int i = 0; i < 27; i++)
         if (v[i]) p = 5'(i);
      return p;
   endfunction

endpackage

// File: rtl/mat_add_seq_adder.sv
// Multi-cycle IEEE-754 single adder: align on load, add, normalise.
// Subnormals flush to zero; low bits truncate; ready holds until acked.
module adder
   import mat_add_seq_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [EW-1:0] Number1,
   input  logic [EW-1:0] Number2,
   input  logic          result_ack,
   output logic [EW-1:0] Result,
   output logic          result_ready
);

   logic [7:0]  w_ea;
   logic [7:0]  w_eb;
   logic [7:0]  w_diff;
   logic [23:0] w_ma;
   logic [23:0] w_mb;
   logic        w_a_big;
   logic [26:0] w_mbig;
   logic [26:0] w_msml;

   logic        r_v1;
   logic        r_v2;
   logic [26:0] r_mbig;
   logic [26:0] r_msml;
   logic [7:0]  r_exp;
   logic        r_sign;
   logic        r_sub;
   logic [27:0] r_sum;
   logic [7:0]  r_exp2;
   logic        r_sign2;
   logic [EW-1:0] r_res;
   logic        r_ready;
   logic        r_ack_seen;

   logic [4:0]  w_lz;
   logic [26:0] w_norm;
   logic [EW-1:0] w_pack;

   // unpack operands, order by magnitude, shift the smaller one
   always_comb begin
      w_ea    = Number1[30:23];
      w_eb    = Number2[30:23];
      w_ma    = (w_ea != '0) ? {1'b1, Number1[22:0]} : '0;
      w_mb    = (w_eb != '0) ? {1'b1, Number2[22:0]} : '0;
      w_a_big = Number1[30:0] >= Number2[30:0];
      w_diff  = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
      w_mbig  = {(w_a_big ? w_ma : w_mb), 3'b000};
      w_msml  = {(w_a_big ? w_mb : w_ma), 3'b000} >> w_diff;
   end

   // renormalise the raw sum and pack it
   always_comb begin
      w_lz   = 5'd26 - f_msb(r_sum[26:0]);
      w_norm = r_sum[26:0] << w_lz;
      w_pack = '0;
      if (r_sum[27])
         w_pack = {r_sign2, r_exp2 + 8'd1, r_sum[26:4]};
      else if (r_sum != '0 && {3'b000, w_lz} < r_exp2)
         w_pack = {r_sign2, r_exp2 - {3'b000, w_lz}, w_norm[25:3]};
   end

   // three-stage datapath plus ready/ack handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_mbig     <= '0;
         r_msml     <= '0;
         r_exp      <= '0;
         r_sign     <= 1'b0;
         r_sub      <= 1'b0;
         r_sum      <= '0;
         r_exp2     <= '0;
         r_sign2    <= 1'b0;
         r_res      <= '0;
         r_ready    <= 1'b0;
         r_ack_seen <= 1'b0;
      end else begin
         r_v1 <= load;
         r_v2 <= r_v1 && !load;
         if (r_v1) begin
            r_sum   <= r_sub ? ({1'b0, r_mbig} - {1'b0, r_msml})
                             : ({1'b0, r_mbig} + {1'b0, r_msml});
            r_exp2  <= r_exp;
            r_sign2 <= r_sign;
         end
         if (load) begin
            r_mbig     <= w_mbig;
            r_msml     <= w_msml;
            r_exp      <= w_a_big ? w_ea : w_eb;
            r_sign     <= w_a_big ? Number1[31] : Number2[31];
            r_sub      <= Number1[31] ^ Number2[31];
            r_ready    <= 1'b0;
            r_ack_seen <= 1'b0;
         end else if (r_v2) begin
            r_res   <= w_pack;
            r_ready <= 1'b1;
         end else if (r_ack_seen) begin
            r_ready    <= 1'b0;
            r_ack_seen <= 1'b0;
         end else if (r_ready && result_ack) begin
            r_ack_seen <= 1'b1;
         end
      end
   end

   assign Result       = r_res;
   assign result_ready = r_ready;

endmodule

// File: rtl/mat_add_seq.sv
// Element-wise matrix adder sharing one FP adder across all elements,
// processed in index order with a per-element timeout.
module mat_add_seq
   import mat_add_seq_pkg::*;
#(
   parameter  int WIDTH   = 2,
   parameter  int TIMEOUT = 64,
   localparam int N       = WIDTH * WIDTH,
   localparam int IW      = (N > 1) ? $clog2(N) : 1,
   localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [EW*N-1:0] A,
   input  logic [EW*N-1:0] B,
   output logic [EW*N-1:0] result,
   output logic            busy,
   output logic            done,
   input  logic            ack,
   output logic            err,
   output logic [IW-1:0]   idx
);

   state_t        r_state;
   state_t        w_next;
   logic [EW-1:0] r_a   [N];
   logic [EW-1:0] r_b   [N];
   logic [EW-1:0] r_res [N];
   logic [IW-1:0] r_idx;
   logic [CW-1:0] r_cnt;
   logic          r_err;

   logic          w_load;
   logic          w_ack;
   logic          w_ready;
   logic          w_busy;
   logic          w_done;
   logic          w_last;
   logic          w_tout;
   logic [EW-1:0] w_sum;

   assign w_last = (r_idx == IW'(N - 1));
   assign w_tout = (r_cnt == CW'(TIMEOUT - 1));

   adder u_adder (
      .clk          (clk),
      .reset        (reset),
      .load         (w_load),
      .Number1      (r_a[r_idx]),
      .Number2      (r_b[r_idx]),
      .result_ack   (w_ack),
      .Result       (w_sum),
      .result_ready (w_ready)
   );

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state logic; ack wins over start in DONE
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (start) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_WAIT;
         S_WAIT:    if (w_ready)     w_next = S_RELEASE;
                    else if (w_tout) w_next = S_DONE;
         S_RELEASE: if (!w_ready) w_next = w_last ? S_DONE : S_ISSUE;
         S_DONE:    if (ack) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // state-decoded outputs and adder strobes
   always_comb begin
      w_load = (r_state == S_ISSUE);
      w_ack  = (r_state == S_WAIT) && w_ready;
      w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT)
            || (r_state == S_RELEASE);
      w_done = (r_state == S_DONE);
   end

   // operand capture, result write-back, index and wait counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_res[k] <= '0;
         end
         r_idx <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (start) begin
               for (int k = 0; k < N; k++) begin
                  r_a[k]   <= A[EW*k +: EW];
                  r_b[k]   <= B[EW*k +: EW];
                  r_res[k] <= '0;
               end
               r_idx <= '0;
               r_err <= 1'b0;
            end
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (w_ready)     r_res[r_idx] <= w_sum;
               else if (w_tout) r_err <= 1'b1;
               else             r_cnt <= r_cnt + 1'b1;
            end
            S_RELEASE: if (!w_ready && !w_last) r_idx <= r_idx + 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_res
      assign result[EW*k +: EW] = r_res[k];
   end

   assign busy = w_busy;
   assign done = w_done;
   assign err  = r_err;
   assign idx  = r_idx;

endmodule

// File: tb/tb_mat_add_seq.sv
// Self-checking bench for mat_add_seq: directed steps plus random
// matrices of fixed-point values checked against exact float sums.
module tb_mat_add_seq;

   localparam int WIDTH   = 2;
   localparam int N       = WIDTH * WIDTH;
   localparam int TIMEOUT = 64;
   localparam int L       = 3;
   localparam int LAT     = N * (L + 3) + 1;
   localparam int VW      = 32 * N;
   localparam logic [VW-1:0] LIT =
      {32'h40900000, 32'h40600000, 32'h40200000, 32'h3FC00000};

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          ack;
   logic [VW-1:0] A;
   logic [VW-1:0] B;
   logic [VW-1:0] result;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    idx;

   int checks = 0;
   int errors = 0;
   int ma [N];
   int mb [N];
   logic [VW-1:0] exp_v;
   int   n_load = 0;
   int   n_done = 0;
   logic done_q = 1'b0;
   int   cyc;
   int   nl0;
   int   nd0;
   bit   flag;

   always #5 clk = ~clk;

   mat_add_seq #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .A      (A),
      .B      (B),
      .result (result),
      .busy   (busy),
      .done   (done),
      .ack    (ack),
      .err    (err),
      .idx    (idx)
   );

   always @(negedge clk) begin
      if (dut.w_load === 1'b1) n_load <= n_load + 1;
      done_q <= done;
      if (done === 1'b1 && done_q !== 1'b1) n_done <= n_done + 1;
   end

   // m * 2^-4 as an IEEE-754 single (exact for |m| < 2^17)
   function automatic logic [31:0] fx2f(input int m);
      int a;
      int p;
      logic [31:0] f;
      if (m == 0) return 32'h0;
      a = (m < 0) ? -m : m;
      p = 0;
      for (int i = 0; i < 31; i++)
         if ((a >> i) != 0) p = i;
      f[31]    = (m < 0);
      f[30:23] = 8'(127 + p - 4);
      f[22:0]  = 23'(a << (23 - p));
      return f;
   endfunction

   task automatic chk(input string tag, input logic [VW-1:0] obs,
                      input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build();
      for (int k = 0; k < N; k++) begin
         A[32*k +: 32]     = fx2f(ma[k]);
         B[32*k +: 32]     = fx2f(mb[k]);
         exp_v[32*k +: 32] = fx2f(ma[k] + mb[k]);
      end
   endtask

   task automatic rand_mats();
      for (int k = 0; k < N; k++) begin
         ma[k] = int'($urandom_range(60000)) - 30000;
         if ($urandom_range(3) == 0) mb[k] = -ma[k];
         else mb[k] = int'($urandom_range(60000)) - 30000;
      end
      build();
   endtask

   task automatic start_op();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int c);
      c = 1;
      while (done !== 1'b1 && c < bound) begin
         tick();
         c++;
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      ack   = 1'b0;
      A     = '0;
      B     = '0;
      exp_v = '0;
      repeat (3) tick();
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_result", result, 0);
      chk("rst_idx", idx, 0);
      reset = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      ma = '{16, 32, 48, 64};
      mb = '{8, 8, 8, 8};
      build();
      chk("model_lit", exp_v, LIT);
      start_op();
      chk("busy_after_start", busy, 1);
      wait_done(LAT + 20, cyc);
      chk("basic_done", done, 1);
      chk("basic_latency", cyc, LAT);
      chk("basic_err", err, 0);
      chk("basic_result", result, LIT);
      chk("basic_busy_low", busy, 0);
      do_ack();
      chk("ack_drop_done", done, 0);

      start_op();
      A = '0;
      wait_done(LAT + 20, cyc);
      chk("frozen_done", done, 1);
      flag = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done !== 1'b1 || result !== LIT) flag = 1'b0;
      end
      chk("hold_stable", flag, 1);
      chk("frozen_result", result, LIT);
      do_ack();
      chk("hold_ack_done", done, 0);
      chk("hold_ack_busy", busy, 0);

      build();
      force dut.w_ready = 1'b0;
      start_op();
      wait_done(TIMEOUT + 20, cyc);
      chk("tout_done", done, 1);
      chk("tout_err", err, 1);
      chk("tout_latency", cyc, TIMEOUT + 2);
      chk("tout_result", result, 0);
      release dut.w_ready;
      do_ack();
      chk("tout_ack_done", done, 0);

      rand_mats();
      start_op();
      cyc = 0;
      while (idx !== 2'd2 && cyc < LAT) begin
         tick();
         cyc++;
      end
      tick();
      chk("mid_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_idx", idx, 0);
      tick();
      reset = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done !== 1'b0) flag = 1'b1;
      end
      chk("mid_no_done", flag, 0);
      start_op();
      wait_done(LAT + 20, cyc);
      chk("mid_new_done", done, 1);
      chk("mid_new_latency", cyc, LAT);
      chk("mid_new_result", result, exp_v);
      do_ack();

      for (int r = 0; r < 4; r++) begin
         rand_mats();
         nl0 = n_load;
         start_op();
         repeat (3) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         wait_done(LAT + 20, cyc);
         chk("rand_done", done, 1);
         chk("rand_err", err, 0);
         chk("rand_result", result, exp_v);
         chk("rand_loads", n_load - nl0, N);
         do_ack();
         repeat (2) tick();
         chk("rand_no_requeue", busy, 0);
      end

      nd0 = n_done;
      start = 1'b1;
      for (int r = 0; r < 3; r++) begin
         rand_mats();
         nl0 = n_load;
         tick();
         wait_done(LAT + 20, cyc);
         chk("b2b_done", done, 1);
         chk("b2b_latency", cyc, LAT);
         chk("b2b_result", result, exp_v);
         chk("b2b_loads", n_load - nl0, N);
         do_ack();
         chk("b2b_idle_done", done, 0);
         chk("b2b_idle_busy", busy, 0);
      end
      start = 1'b0;
      tick();
      tick();
      chk("b2b_done_count", n_done - nd0, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
